// File: rtl/data_out_collect_if.sv
// -----------------------------------------------------------------------------
// data_out_collect_if
// Bundles the chunk-collector handshake: the run enable and incoming chunk
// from the serializer side, and the assembled word, strobes and group counter
// on the consumer side.
//   run          : collect enable (low = idle and clear)
//   input_data   : one CW-bit chunk per run cycle
//   output_data  : assembled 4*CW-bit word, chunk k at bits [(k+1)*CW-1 : k*CW]
//   output_valid : one-cycle strobe, output_data holds a new word
//   frame_done   : one-cycle strobe at frame end
//   group_cnt    : complete words emitted in the current frame
// Modports: master = stimulus/serializer side, slave = collector.
// -----------------------------------------------------------------------------
interface data_out_collect_if #(
   parameter int BIT_LENGTH = 16,
   parameter int DATA_N     = 6
);
   localparam int CW = BIT_LENGTH * DATA_N;

   logic            run;
   logic [CW-1:0]   input_data;
   logic [4*CW-1:0] output_data;
   logic            output_valid;
   logic            frame_done;
   logic [4:0]      group_cnt;

   modport master (
      output run,
      output input_data,
      input  output_data,
      input  output_valid,
      input  frame_done,
      input  group_cnt
   );

   modport slave (
      input  run,
      input  input_data,
      output output_data,
      output output_valid,
      output frame_done,
      output group_cnt
   );
endinterface

// File: rtl/data_out_collect.sv
// -----------------------------------------------------------------------------
// data_out_collect
// Collects CW-bit chunks (one per run cycle) into a 4-slot buffer and emits a
// 4*CW-bit word every fourth chunk. A frame is FRAME_LEN run cycles; at its
// last cycle frame_done pulses and the slot/frame counters restart.
// Ports:
//   clk   : single clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : data_out_collect_if.slave (run, input_data, output_data,
//           output_valid, frame_done, group_cnt)
// Configuration macro: PARTIAL_FLUSH_EN -- when defined, a partial group left
// at frame end is flushed (unfilled upper slots zero) together with
// frame_done; when undefined the partial group is discarded silently.
// -----------------------------------------------------------------------------
module data_out_collect #(
   parameter int BIT_LENGTH = 16,
   parameter int DATA_N     = 6,
   parameter int FRAME_LEN  = 102
) (
   input  logic                clk,
   input  logic                rst_n,
   data_out_collect_if.slave   bus
);
   localparam int CW  = BIT_LENGTH * DATA_N;
   localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_LEN - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t          state_r;
   logic [FCW-1:0]  fc_r;
   logic [1:0]      sc_r;
   logic [CW-1:0]   slot_r [4];
   logic [4*CW-1:0] output_data_r;
   logic            output_valid_r;
   logic            frame_done_r;
   logic [4:0]      group_cnt_r;

   logic            last_s;
   logic [4:0]      cnt_base_s;
   logic [4*CW-1:0] full_word_s;

   assign last_s      = (fc_r == FC_LAST);
   // group_cnt shows its final value during the frame_done cycle and restarts
   // from zero on the following edge.
   assign cnt_base_s  = (frame_done_r || (state_r == IDLE)) ? 5'd0 : group_cnt_r;
   assign full_word_s = {bus.input_data, slot_r[2], slot_r[1], slot_r[0]};

`ifdef PARTIAL_FLUSH_EN
   logic [4*CW-1:0] partial_word_s;

   // Partial word: slots below sc, current chunk at sc, zeros above.
   always_comb begin
      partial_word_s = '0;
      case (sc_r)
         2'd0:    partial_word_s = {{(3*CW){1'b0}}, bus.input_data};
         2'd1:    partial_word_s = {{(2*CW){1'b0}}, bus.input_data, slot_r[0]};
         2'd2:    partial_word_s = {{CW{1'b0}}, bus.input_data, slot_r[1], slot_r[0]};
         default: partial_word_s = full_word_s;
      endcase
   end
`endif

   // Collector FSM: state follows run; counters, buffer and outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         fc_r           <= '0;
         sc_r           <= 2'd0;
         for (int i = 0; i < 4; i++) slot_r[i] <= '0;
         output_data_r  <= '0;
         output_valid_r <= 1'b0;
         frame_done_r   <= 1'b0;
         group_cnt_r    <= 5'd0;
      end else begin
         case (bus.run)
            1'b1: begin
               state_r        <= COLLECT;
               slot_r[sc_r]   <= bus.input_data;
               output_valid_r <= 1'b0;
               frame_done_r   <= 1'b0;
               group_cnt_r    <= cnt_base_s;
               if (last_s) begin
                  // Frame end overrides the mod-4 slot step.
                  fc_r         <= '0;
                  sc_r         <= 2'd0;
                  frame_done_r <= 1'b1;
                  if (sc_r == 2'd3) begin
                     output_data_r  <= full_word_s;
                     output_valid_r <= 1'b1;
                     group_cnt_r    <= cnt_base_s + 5'd1;
                  end else begin
`ifdef PARTIAL_FLUSH_EN
                     output_data_r  <= partial_word_s;
                     output_valid_r <= 1'b1;
`else
                     output_data_r  <= output_data_r;
`endif
                  end
               end else begin
                  fc_r <= fc_r + {{(FCW-1){1'b0}}, 1'b1};
                  sc_r <= sc_r + 2'd1;
                  if (sc_r == 2'd3) begin
                     output_data_r  <= full_word_s;
                     output_valid_r <= 1'b1;
                     group_cnt_r    <= cnt_base_s + 5'd1;
                  end else begin
                     output_data_r  <= output_data_r;
                  end
               end
            end
            default: begin
               // run low: drop any partial group and clear everything.
               state_r        <= IDLE;
               fc_r           <= '0;
               sc_r           <= 2'd0;
               for (int i = 0; i < 4; i++) slot_r[i] <= '0;
               output_data_r  <= '0;
               output_valid_r <= 1'b0;
               frame_done_r   <= 1'b0;
               group_cnt_r    <= 5'd0;
            end
         endcase
      end
   end

   assign bus.output_data  = output_data_r;
   assign bus.output_valid = output_valid_r;
   assign bus.frame_done   = frame_done_r;
   assign bus.group_cnt    = group_cnt_r;
endmodule

// File: tb/tb_data_out_collect.sv
// -----------------------------------------------------------------------------
// tb_data_out_collect
// Directed self-checking bench for data_out_collect (default parameters).
// Inputs change on the falling edge; outputs are read on the next falling
// edge, i.e. half a cycle after the rising edge that produced them.
// Honours PARTIAL_FLUSH_EN for the frame-end expectations.
// -----------------------------------------------------------------------------
module tb_data_out_collect;
   localparam int CW = 96;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   data_out_collect_if #(.BIT_LENGTH(16), .DATA_N(6)) bus ();

   data_out_collect dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one chunk, then wait until the following falling edge.
   task automatic drive(input logic r, input logic [CW-1:0] d);
      bus.run        = r;
      bus.input_data = d;
      @(negedge clk);
   endtask

   function automatic logic [4*CW-1:0] w4(input int a3, input int a2, input int a1, input int a0);
      return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
   endfunction

   task automatic test_reset;
      rst_n          = 1'b0;
      bus.run        = 1'b0;
      bus.input_data = '0;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.output_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.output_data); end
      total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.output_valid); end
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
      total++; if (bus.group_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.group_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_first_word;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, CW'(k + 1));
         if (k < 3) begin
            total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL first_early_valid k=%0d got=%b want=0", k, bus.output_valid); end
         end
      end
      total++; if (bus.output_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", bus.output_valid); end
      total++; if (bus.output_data !== w4(4, 3, 2, 1)) begin bad++; $display("FAIL first_data got=%h want=%h", bus.output_data, w4(4, 3, 2, 1)); end
      total++; if (bus.group_cnt !== 5'd1) begin bad++; $display("FAIL first_cnt got=%0d want=1", bus.group_cnt); end
      drive(1'b1, CW'(5));
      total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL first_valid_drop got=%b want=0", bus.output_valid); end
      drive(1'b0, '0);
   endtask

   // One full frame with chunk value = frame index; assumes fc=0, sc=0 on entry.
   task automatic test_full_frame;
      logic            exp_v;
      logic [4*CW-1:0] exp_end;
      int              pulses;
      pulses = 0;
      for (int j = 1; j <= 102; j++) begin
         drive(1'b1, CW'(j - 1));
         exp_v = ((j % 4) == 0) && (j <= 100);
         if (bus.output_valid === 1'b1 && exp_v) pulses++;
`ifdef PARTIAL_FLUSH_EN
         if (j == 102) exp_v = 1'b1;
`endif
         total++; if (bus.output_valid !== exp_v) begin bad++; $display("FAIL frame_valid edge=%0d got=%b want=%b", j, bus.output_valid, exp_v); end
         total++; if (bus.frame_done !== (j == 102)) begin bad++; $display("FAIL frame_fd edge=%0d got=%b want=%b", j, bus.frame_done, (j == 102)); end
         if (((j % 4) == 0) && (j <= 100)) begin
            total++; if (bus.output_data !== w4(j - 1, j - 2, j - 3, j - 4)) begin bad++; $display("FAIL frame_data edge=%0d got=%h want=%h", j, bus.output_data, w4(j - 1, j - 2, j - 3, j - 4)); end
            total++; if (bus.group_cnt !== 5'(j / 4)) begin bad++; $display("FAIL frame_cnt edge=%0d got=%0d want=%0d", j, bus.group_cnt, j / 4); end
         end
      end
`ifdef PARTIAL_FLUSH_EN
      exp_end = w4(0, 0, 101, 100);
`else
      exp_end = w4(99, 98, 97, 96);
`endif
      total++; if (bus.output_data !== exp_end) begin bad++; $display("FAIL frame_end_data got=%h want=%h", bus.output_data, exp_end); end
      total++; if (bus.group_cnt !== 5'd25) begin bad++; $display("FAIL frame_end_cnt got=%0d want=25", bus.group_cnt); end
      total++; if (pulses !== 25) begin bad++; $display("FAIL frame_pulses got=%0d want=25", pulses); end
      drive(1'b1, '0);
      total++; if (bus.group_cnt !== 5'd0) begin bad++; $display("FAIL frame_cnt_restart got=%0d want=0", bus.group_cnt); end
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL frame_fd_clear got=%b want=0", bus.frame_done); end
      total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL frame_valid_clear got=%b want=0", bus.output_valid); end
      drive(1'b0, '0);
   endtask

   task automatic test_run_drop;
      for (int j = 1; j <= 6; j++) begin
         drive(1'b1, CW'(32'h10 + j));
         if (j > 4) begin
            total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL drop_partial_valid edge=%0d got=%b want=0", j, bus.output_valid); end
         end
      end
      drive(1'b0, {CW{1'b1}});
      total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b want=0", bus.output_valid); end
      total++; if (bus.output_data !== '0) begin bad++; $display("FAIL drop_data got=%h want=0", bus.output_data); end
      total++; if (bus.group_cnt !== 5'd0) begin bad++; $display("FAIL drop_cnt got=%0d want=0", bus.group_cnt); end
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL drop_fd got=%b want=0", bus.frame_done); end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, CW'(32'hB0 + k));
         if (k < 3) begin
            total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL restart_early_valid k=%0d got=%b want=0", k, bus.output_valid); end
         end
      end
      total++; if (bus.output_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b want=1", bus.output_valid); end
      total++; if (bus.output_data !== w4(32'hB3, 32'hB2, 32'hB1, 32'hB0)) begin bad++; $display("FAIL restart_data got=%h want=%h", bus.output_data, w4(32'hB3, 32'hB2, 32'hB1, 32'hB0)); end
      total++; if (bus.group_cnt !== 5'd1) begin bad++; $display("FAIL restart_cnt got=%0d want=1", bus.group_cnt); end
      drive(1'b0, '0);
   endtask

   task automatic test_reset_mid;
      for (int j = 1; j <= 50; j++) drive(1'b1, CW'(j + 7));
      total++; if (bus.group_cnt !== 5'd12) begin bad++; $display("FAIL mid_cnt_before got=%0d want=12", bus.group_cnt); end
      #2;
      rst_n   = 1'b0;
      bus.run = 1'b0;
      #1;
      total++; if (bus.output_data !== '0) begin bad++; $display("FAIL async_data got=%h want=0", bus.output_data); end
      total++; if (bus.group_cnt !== 5'd0) begin bad++; $display("FAIL async_cnt got=%0d want=0", bus.group_cnt); end
      total++; if (bus.output_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", bus.output_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      test_full_frame();
   endtask

   task automatic test_back_to_back;
      logic [CW-1:0]   pat [8];
      logic [4*CW-1:0] exp_w;
      pat[0] = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
      pat[1] = 96'h5555_AAAA_5555_AAAA_5555_AAAA;
      pat[2] = 96'hFFFF_0000_FFFF_0000_1234_5678;
      pat[3] = 96'h8000_0000_0000_0000_0000_0001;
      pat[4] = 96'h0F0F_F0F0_0F0F_F0F0_0F0F_F0F0;
      pat[5] = 96'hCAFE_BABE_FACE_FEED_C0DE_D00D;
      pat[6] = 96'h0000_0000_0000_0000_0000_0000;
      pat[7] = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      for (int g = 0; g < 2; g++) begin
         for (int k = 0; k < 4; k++) drive(1'b1, pat[g * 4 + k]);
         exp_w = {pat[g * 4 + 3], pat[g * 4 + 2], pat[g * 4 + 1], pat[g * 4]};
         total++; if (bus.output_valid !== 1'b1) begin bad++; $display("FAIL loop_valid g=%0d got=%b want=1", g, bus.output_valid); end
         total++; if (bus.output_data !== exp_w) begin bad++; $display("FAIL loop_data g=%0d got=%h want=%h", g, bus.output_data, exp_w); end
         total++; if (bus.group_cnt !== 5'(g + 1)) begin bad++; $display("FAIL loop_cnt g=%0d got=%0d want=%0d", g, bus.group_cnt, g + 1); end
      end
      drive(1'b0, '0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      @(negedge clk);
      test_reset();
      test_first_word();
      test_full_frame();
      test_run_drop();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_out_collect.md
DATA_OUT_COLLECT -- requirements
Module: data_out_collect

Interface
REQ-001 Parameter BIT_LENGTH, default 16, width of one data element.
REQ-002 Parameter DATA_N, default 6, elements per input chunk; chunk width CW = BIT_LENGTH*DATA_N (96).
REQ-003 Parameter FRAME_LEN, default 102, run cycles per frame.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  collect enable; low = idle and clear.
REQ-007 input_data  input  CW  one chunk per run cycle, from the chunk serializer's output_data.
REQ-008 output_data  output  4*CW  assembled word; chunk k in bits [(k+1)*CW-1 : k*CW].
REQ-009 output_valid  output  1  one-cycle strobe, output_data holds a new word.
REQ-010 frame_done  output  1  one-cycle strobe at frame end.
REQ-011 group_cnt  output  5  complete words emitted in the current frame, 0..25.

Function
REQ-012 States: IDLE (run=0) and COLLECT (run=1); transition on every edge follows run directly.
REQ-013 Internal counters: frame counter fc 0..FRAME_LEN-1, slot counter sc 0..3.
REQ-014 In COLLECT, each edge writes input_data into slot sc of a 4-slot assembly buffer.
REQ-015 sc increments mod 4; fc increments; when fc==FRAME_LEN-1, fc<=0 and sc<=0 on the same edge, overriding the mod-4 step.
REQ-016 When sc==3 and fc!=FRAME_LEN-1: output_data <= {input_data, slot2, slot1, slot0}, output_valid<=1, group_cnt<=group_cnt+1.
REQ-017 Latency: output_valid is high in the cycle immediately after the edge that samples chunk 3; low in all other cycles.
REQ-018 When fc==FRAME_LEN-1: frame_done<=1 for one cycle, group_cnt<=0 on the following edge after being visible with final value (25) during the frame_done cycle.
REQ-019 Frame-end partial group (FRAME_LEN=102 leaves chunks 0,1 of group 26): handled per REQ-026/027.
REQ-020 Coincidence sc==3 with fc==FRAME_LEN-1 (other FRAME_LEN values): complete word emitted as in REQ-016 and frame_done asserted in the same cycle.
REQ-021 Alignment: run is driven one cycle later than the serializer's run, so chunk k arrives when sc==k.
REQ-022 run deasserted mid-frame: next edge clears fc, sc, assembly buffer, output_data, output_valid, frame_done, group_cnt to 0; partial group discarded, no strobe.
REQ-023 run reasserted: collection restarts at fc=0, sc=0.

Reset
REQ-024 rst_n low: immediately and asynchronously clear fc, sc, assembly buffer, output_data, output_valid, frame_done, group_cnt to 0.
REQ-025 Reset mid-frame discards all collected data; first edge after release with run=1 samples slot 0.

Configuration
REQ-026 Macro PARTIAL_FLUSH_EN defined: on fc==FRAME_LEN-1 with sc!=3, output_data <= collected slots 0..sc (including current input_data), unfilled upper slots zero, output_valid<=1 coincident with frame_done; group_cnt not incremented.
REQ-027 PARTIAL_FLUSH_EN undefined: partial group silently discarded; output_data keeps previous word, output_valid stays 0.

Verification
REQ-028 Reset, run=1, input_data=k+1 each cycle k=0..3 -> cycle after edge 4: output_valid=1, output_data={4,3,2,1} chunks, group_cnt=1.
REQ-029 Full 102-cycle frame, incrementing data -> exactly 25 output_valid pulses spaced 4 cycles, frame_done once after 102nd edge, group_cnt=25 then 0.
REQ-030 Chunks 100,101 at frame end -> with PARTIAL_FLUSH_EN: output_data={0,0,101,100}, output_valid and frame_done together; without: output_valid=0, output_data unchanged.
REQ-031 run dropped after 6 cycles (sc=2), raised again -> no strobe, all outputs 0, next word assembles from fresh chunks 0..3.
REQ-032 rst_n pulsed low mid-cycle at fc=50 -> outputs 0 without clock edge; subsequent frame behaves as REQ-029.
REQ-033 Loopback with serializer (its run one cycle earlier), 4 distinct 96-bit patterns -> every output_data equals serializer input bundle.
